// File: rtl/digicode_pkg.sv
// Shared definitions for the digicode keypad arbiter: key encodings,
// FSM state type and a sizing helper for the shared down-counter.
package digicode_pkg;

   // Keypad key encodings
   localparam logic [3:0] KEY_ZERO  = 4'h0;
   localparam logic [3:0] KEY_ONE   = 4'h1;
   localparam logic [3:0] KEY_TWO   = 4'h2;
   localparam logic [3:0] KEY_THREE = 4'h3;
   localparam logic [3:0] KEY_FOUR  = 4'h4;
   localparam logic [3:0] KEY_FIVE  = 4'h5;
   localparam logic [3:0] KEY_SIX   = 4'h6;
   localparam logic [3:0] KEY_SEVEN = 4'h7;
   localparam logic [3:0] KEY_EIGHT = 4'h8;
   localparam logic [3:0] KEY_NINE  = 4'h9;
   localparam logic [3:0] KEY_A     = 4'hA;
   localparam logic [3:0] KEY_B     = 4'hB;
   localparam logic [3:0] KEY_C     = 4'hC;  // clear
   localparam logic [3:0] KEY_P     = 4'hD;

   // Arbiter FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SESSION = 3'd1,
      ST_DOOR    = 3'd2,
      ST_ALARM   = 3'd3,
      ST_LOCK    = 3'd4
   } state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Width of the shared timer. The key timeout is included with the hold
   // durations so that every value ever loaded into the counter fits.
   function automatic int timer_width(input int key_timeout, input int door_hold,
                                      input int alarm_hold, input int lockout);
      return $clog2(max_of(max_of(key_timeout, door_hold),
                           max_of(alarm_hold, lockout))) + 1;
   endfunction

endpackage

// File: rtl/digicode_arbiter_timer.sv
// dc_timer: loadable down-counter shared by every timed arbiter state.
// It counts down to zero and then stays there; expire flags the last
// counted cycle (count == 1), so a load of N gives exactly N cycles.
module dc_timer
   import digicode_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expire
);

   logic [WIDTH-1:0] count;

   // Load has priority over counting; the counter saturates at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/digicode_arbiter.sv
// digicode_arbiter: grants one of two keypads exclusive access to a
// shared digicode, forwards that keypad's keys, and sequences the door,
// alarm and lockout phases reported back by the digicode.
module digicode_arbiter
   import digicode_pkg::*;
#(
   parameter int KEY_TIMEOUT = 64,
   parameter int DOOR_HOLD   = 32,
   parameter int ALARM_HOLD  = 32,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT     = 256
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key0,
   input  logic [3:0] key1,
   input  logic       key0_valid,
   input  logic       key1_valid,
   output logic [3:0] dc_code,
   output logic       dc_timeout,
   output logic       dc_reset,
   input  logic       dc_door,
   input  logic       dc_alarm,
   output logic       owner,
   output logic       busy,
   output logic       door_open,
   output logic       alarm_out,
   output logic       locked
);

   localparam int TW = timer_width(KEY_TIMEOUT, DOOR_HOLD, ALARM_HOLD, LOCKOUT);
   localparam int FW = $clog2(MAX_FAIL + 1);

   localparam logic [TW-1:0] LOAD_KEY   = TW'(KEY_TIMEOUT);
   localparam logic [TW-1:0] LOAD_DOOR  = TW'(DOOR_HOLD);
   localparam logic [TW-1:0] LOAD_ALARM = TW'(ALARM_HOLD);
   localparam logic [TW-1:0] LOAD_LOCK  = TW'(LOCKOUT);
   localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);

   state_t          state_q, state_d;
   logic [3:0]      code_q, code_d;
   logic            dc_reset_q, dc_reset_d;
   logic            owner_q, owner_d;
   logic            last_owner_q, last_owner_d;
   logic [FW-1:0]   fail_q, fail_d;

   logic            tmr_load;
   logic [TW-1:0]   tmr_value;
   logic            tmr_expire;

   // Arbitration and owner-key selection helpers
   logic            elig0, elig1, grant_any, grant_pad;
   logic            own_valid;
   logic [3:0]      own_key;

   // A clear key never opens a session; a tie goes to the keypad that
   // did not hold the previous session.
   assign elig0     = key0_valid && (key0 != KEY_C);
   assign elig1     = key1_valid && (key1 != KEY_C);
   assign grant_any = elig0 || elig1;
   assign grant_pad = (elig0 && elig1) ? ~last_owner_q : elig1;

   // Only the session owner's keypad is listened to while a session runs.
   assign own_valid = owner_q ? key1_valid : key0_valid;
   assign own_key   = owner_q ? key1 : key0;

   dc_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .value  (tmr_value),
      .expire (tmr_expire)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-datapath logic, including timer reloads.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      code_d       = code_q;
      dc_reset_d   = 1'b0;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      fail_d       = fail_q;
      tmr_load     = 1'b0;
      tmr_value    = '0;

      case (state_q)
         ST_IDLE: begin
            code_d = KEY_C;
            if (grant_any) begin
               state_d      = ST_SESSION;
               owner_d      = grant_pad;
               last_owner_d = grant_pad;
               code_d       = grant_pad ? key1 : key0;
               tmr_load     = 1'b1;
               tmr_value    = LOAD_KEY;
            end
         end

         ST_SESSION: begin
            // Digicode status outranks keys; alarm outranks door.
            if (dc_alarm) begin
               state_d   = ST_ALARM;
               if (fail_q < FAIL_MAX) begin
                  fail_d = fail_q + FW'(1);
               end
               tmr_load  = 1'b1;
               tmr_value = LOAD_ALARM;
            end else if (dc_door) begin
               state_d   = ST_DOOR;
               fail_d    = '0;
               tmr_load  = 1'b1;
               tmr_value = LOAD_DOOR;
            end else if (own_valid) begin
               if (own_key == KEY_C) begin
                  state_d    = ST_IDLE;
                  code_d     = KEY_C;
                  dc_reset_d = 1'b1;
               end else begin
                  code_d    = own_key;
                  tmr_load  = 1'b1;
                  tmr_value = LOAD_KEY;
               end
            end
         end

         ST_DOOR: begin
            if (tmr_expire) begin
               state_d    = ST_IDLE;
               code_d     = KEY_C;
               dc_reset_d = 1'b1;
            end
         end

         ST_ALARM: begin
            if (tmr_expire) begin
               code_d = KEY_C;
               if (fail_q == FAIL_MAX) begin
                  state_d   = ST_LOCK;
                  tmr_load  = 1'b1;
                  tmr_value = LOAD_LOCK;
               end else begin
                  state_d    = ST_IDLE;
                  dc_reset_d = 1'b1;
               end
            end
         end

         ST_LOCK: begin
            code_d = KEY_C;
            if (tmr_expire) begin
               state_d    = ST_IDLE;
               fail_d     = '0;
               dc_reset_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            code_d  = KEY_C;
         end
      endcase
   end

   // Session bookkeeping and the registered strobes sent to the digicode.
   always_ff @(posedge clk) begin
      if (reset) begin
         code_q       <= KEY_C;
         dc_reset_q   <= 1'b1;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         fail_q       <= '0;
      end else begin
         code_q       <= code_d;
         dc_reset_q   <= dc_reset_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         fail_q       <= fail_d;
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy       = (state_q == ST_SESSION);
      door_open  = (state_q == ST_DOOR);
      alarm_out  = (state_q == ST_ALARM);
      locked     = (state_q == ST_LOCK);
      dc_timeout = (state_q == ST_SESSION) && tmr_expire;
   end

   assign dc_code  = code_q;
   assign dc_reset = dc_reset_q;
   assign owner    = owner_q;

endmodule

// File: tb/tb_digicode_arbiter.sv
// Self-checking bench for digicode_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// deadline-based behavioural model.
module tb_digicode_arbiter;
   import digicode_pkg::*;

   localparam int KEY_TIMEOUT = 64;
   localparam int DOOR_HOLD   = 32;
   localparam int ALARM_HOLD  = 32;
   localparam int MAX_FAIL    = 3;
   localparam int LOCKOUT     = 256;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] key0 = 4'h0, key1 = 4'h0;
   logic       key0_valid = 1'b0, key1_valid = 1'b0;
   logic       dc_door = 1'b0, dc_alarm = 1'b0;
   logic [3:0] dc_code;
   logic       dc_timeout, dc_reset, owner, busy, door_open, alarm_out, locked;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   digicode_arbiter #(
      .KEY_TIMEOUT (KEY_TIMEOUT),
      .DOOR_HOLD   (DOOR_HOLD),
      .ALARM_HOLD  (ALARM_HOLD),
      .MAX_FAIL    (MAX_FAIL),
      .LOCKOUT     (LOCKOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key0       (key0),
      .key1       (key1),
      .key0_valid (key0_valid),
      .key1_valid (key1_valid),
      .dc_code    (dc_code),
      .dc_timeout (dc_timeout),
      .dc_reset   (dc_reset),
      .dc_door    (dc_door),
      .dc_alarm   (dc_alarm),
      .owner      (owner),
      .busy       (busy),
      .door_open  (door_open),
      .alarm_out  (alarm_out),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model. Timed phases are absolute windows of cycle
   // numbers: a phase is active while m_cyc < its end cycle.
   // ------------------------------------------------------------------
   int         m_cyc = 0;
   bit         m_sess = 1'b0;
   bit         m_owner = 1'b0;
   bit         m_last = 1'b1;
   int         m_fails = 0;
   int         m_door_end = 0, m_alarm_end = 0, m_lock_end = 0;
   int         m_key_time = -100000;
   logic [3:0] m_code = 4'hC;
   bit         m_rst = 1'b1;

   always @(posedge clk) begin
      bit         e0, e1, pad, kv;
      logic [3:0] kc;
      m_rst = 1'b0;
      if (reset) begin
         m_sess = 0; m_owner = 0; m_last = 1; m_fails = 0;
         m_door_end = 0; m_alarm_end = 0; m_lock_end = 0;
         m_key_time = -100000; m_code = 4'hC; m_rst = 1;
      end else if (m_cyc < m_door_end) begin
         if (m_cyc == m_door_end - 1) begin m_code = 4'hC; m_rst = 1; end
      end else if (m_cyc < m_alarm_end) begin
         if (m_cyc == m_alarm_end - 1) begin
            m_code = 4'hC;
            if (m_fails == MAX_FAIL) m_lock_end = m_cyc + 1 + LOCKOUT;
            else m_rst = 1;
         end
      end else if (m_cyc < m_lock_end) begin
         if (m_cyc == m_lock_end - 1) begin m_fails = 0; m_rst = 1; m_code = 4'hC; end
      end else if (m_sess) begin
         kv = m_owner ? key1_valid : key0_valid;
         kc = m_owner ? key1 : key0;
         if (dc_alarm) begin
            m_fails = (m_fails < MAX_FAIL) ? m_fails + 1 : m_fails;
            m_sess = 0; m_alarm_end = m_cyc + 1 + ALARM_HOLD;
         end else if (dc_door) begin
            m_fails = 0; m_sess = 0; m_door_end = m_cyc + 1 + DOOR_HOLD;
         end else if (kv) begin
            if (kc == 4'hC) begin m_sess = 0; m_code = 4'hC; m_rst = 1; end
            else begin m_code = kc; m_key_time = m_cyc; end
         end
      end else begin
         e0 = key0_valid && key0 != 4'hC;
         e1 = key1_valid && key1 != 4'hC;
         if (e0 || e1) begin
            pad = (e0 && e1) ? !m_last : e1;
            m_sess = 1; m_owner = pad; m_last = pad;
            m_code = pad ? key1 : key0;
            m_key_time = m_cyc;
         end
      end
      m_cyc++;
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (started) begin
         check("dc_code",    dc_code,    m_code);
         check("dc_reset",   dc_reset,   m_rst);
         check("dc_timeout", dc_timeout, m_sess && (m_cyc == m_key_time + KEY_TIMEOUT));
         check("owner",      owner,      m_owner);
         check("busy",       busy,       m_sess);
         check("door_open",  door_open,  m_cyc < m_door_end);
         check("alarm_out",  alarm_out,  m_cyc < m_alarm_end);
         check("locked",     locked,     m_cyc < m_lock_end);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (called at a falling edge)
   // ------------------------------------------------------------------
   task automatic press(input int pad, input logic [3:0] k);
      if (pad == 0) begin key0 = k; key0_valid = 1'b1; end
      else begin key1 = k; key1_valid = 1'b1; end
      @(negedge clk);
      key0_valid = 1'b0;
      key1_valid = 1'b0;
   endtask

   task automatic run_alarm(input logic with_door, output int len);
      press(0, 4'd5);
      dc_alarm = 1'b1;
      dc_door  = with_door;
      @(negedge clk);
      dc_alarm = 1'b0;
      dc_door  = 1'b0;
      check("alarm_wins_door", door_open, 1'b0);
      len = 0;
      while (alarm_out && len < 100) begin
         len++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset values
      @(negedge clk);
      started = 1'b1;
      check("rst_code", dc_code, 4'hC);
      check("rst_dc_reset", dc_reset, 1'b1);
      check("rst_owner", owner, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_locked", locked, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_dc_reset", dc_reset, 1'b0);

      // Simultaneous grant after reset goes to keypad 0
      key0 = 4'd1; key1 = 4'd5; key0_valid = 1'b1; key1_valid = 1'b1;
      @(negedge clk);
      key0_valid = 1'b0; key1_valid = 1'b0;
      check("tie_owner0", owner, 1'b0);
      check("tie_code0", dc_code, 4'd1);
      for (int i = 0; i < 6; i++) begin
         key1 = 4'd7; key1_valid = 1'b1;
         @(negedge clk);
         key1_valid = 1'b0;
         check("other_pad_dropped", dc_code, 4'd1);
      end
      press(0, 4'hC);
      check("clear_dc_reset", dc_reset, 1'b1);
      check("clear_idle", busy, 1'b0);
      key0 = 4'd3; key1 = 4'd4; key0_valid = 1'b1; key1_valid = 1'b1;
      @(negedge clk);
      key0_valid = 1'b0; key1_valid = 1'b0;
      check("tie_owner1", owner, 1'b1);
      check("tie_code1", dc_code, 4'd4);
      press(1, 4'hC);

      // Code 2,8,B,0,4 then door
      press(0, 4'd2); @(negedge clk);
      press(0, 4'd8); @(negedge clk);
      press(0, 4'hB); @(negedge clk);
      press(0, 4'd0); @(negedge clk);
      press(0, 4'd4);
      check("code_last_key", dc_code, 4'd4);
      dc_door = 1'b1;
      @(negedge clk);
      dc_door = 1'b0;
      n = 0;
      while (door_open && n < 100) begin n++; @(negedge clk); end
      check("door_len", n, DOOR_HOLD);
      check("door_exit_reset", dc_reset, 1'b1);
      check("door_exit_code", dc_code, 4'hC);

      // Keypad 1 sends one key and goes quiet
      press(1, 4'd2);
      n = 1;
      while (!dc_timeout && n < 200) begin @(negedge clk); n++; end
      check("timeout_latency", n, KEY_TIMEOUT);
      n = 0;
      repeat (80) begin @(negedge clk); if (dc_timeout) n++; end
      check("timeout_once", n, 0);
      check("timeout_stays_session", busy, 1'b1);
      press(1, 4'hC);

      // Three failed sessions lead to lockout
      for (int i = 0; i < 3; i++) begin
         run_alarm(1'b0, n);
         check("alarm_len", n, ALARM_HOLD);
         check("alarm_lock_state", locked, (i == 2) ? 1'b1 : 1'b0);
      end
      n = 0;
      while (locked && n < 400) begin
         key0 = 4'($urandom_range(0, 13)); key0_valid = 1'($urandom_range(0, 1));
         key1 = 4'($urandom_range(0, 13)); key1_valid = 1'($urandom_range(0, 1));
         n++;
         @(negedge clk);
      end
      key0_valid = 1'b0; key1_valid = 1'b0;
      check("lock_len", n, LOCKOUT);
      check("lock_exit_reset", dc_reset, 1'b1);
      check("lock_exit_code", dc_code, 4'hC);

      // Clear keeps the fail count; door+alarm counts as alarm
      press(0, 4'd2);
      press(0, 4'hC);
      check("c_dc_reset", dc_reset, 1'b1);
      check("c_idle", busy, 1'b0);
      run_alarm(1'b0, n);
      check("fail1_len", n, ALARM_HOLD);
      press(0, 4'd7);
      press(0, 4'hC);
      run_alarm(1'b1, n);
      check("both_alarm_len", n, ALARM_HOLD);
      check("fail2_unlocked", locked, 1'b0);
      run_alarm(1'b0, n);
      check("fail3_locked", locked, 1'b1);

      // Reset at lockout cycle 100
      repeat (99) @(negedge clk);
      check("lock_cycle100", locked, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("lock_rst_locked", locked, 1'b0);
      check("lock_rst_code", dc_code, 4'hC);
      check("lock_rst_busy", busy, 1'b0);
      reset = 1'b0;

      // Random traffic: busy keypads, then sparse keys so timeouts occur
      for (int i = 0; i < 5000; i++) begin
         key0 = 4'($urandom_range(0, 13)); key0_valid = ($urandom_range(0, 3) == 0);
         key1 = 4'($urandom_range(0, 13)); key1_valid = ($urandom_range(0, 3) == 0);
         dc_door  = ($urandom_range(0, 29) == 0);
         dc_alarm = ($urandom_range(0, 39) == 0);
         reset    = ($urandom_range(0, 599) == 0);
         @(negedge clk);
      end
      for (int i = 0; i < 3000; i++) begin
         key0 = 4'($urandom_range(0, 13)); key0_valid = ($urandom_range(0, 79) == 0);
         key1 = 4'($urandom_range(0, 13)); key1_valid = ($urandom_range(0, 79) == 0);
         dc_door  = ($urandom_range(0, 149) == 0);
         dc_alarm = ($urandom_range(0, 149) == 0);
         reset    = 1'b0;
         @(negedge clk);
      end
      key0_valid = 1'b0; key1_valid = 1'b0;
      dc_door = 1'b0; dc_alarm = 1'b0; reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/digicode_arbiter.md
DIGICODE_ARBITER -- requirements
Module: digicode_arbiter

Interface
REQ-001 Parameter KEY_TIMEOUT, default 64: inter-key inactivity limit, in clk cycles.
REQ-002 Parameter DOOR_HOLD, default 32: door_open duration, in clk cycles.
REQ-003 Parameter ALARM_HOLD, default 32: alarm_out duration, in clk cycles.
REQ-004 Parameter MAX_FAIL, default 3: consecutive alarms that trigger lockout.
REQ-005 Parameter LOCKOUT, default 256: lockout duration, in clk cycles.
REQ-006 Single clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 key0, key1  in  4 each  keypad key codes: 0-9, A=1010, B=1011, C=1100 (clear), P=1101.
REQ-010 key0_valid, key1_valid  in  1 each  single-cycle keypress strobes.
REQ-011 dc_code  out  4  registered key code driven to the shared digicode.
REQ-012 dc_timeout  out  1  timeout strobe to the digicode.
REQ-013 dc_reset  out  1  reset strobe to the digicode.
REQ-014 dc_door, dc_alarm  in  1 each  digicode door and alarm status.
REQ-015 owner  out  1  index of the keypad holding the session.
REQ-016 busy  out  1  session active.
REQ-017 door_open, alarm_out, locked  out  1 each  system status outputs.

Function
REQ-018 FSM states: IDLE, SESSION, DOOR, ALARM, LOCK.
REQ-019 IDLE: dc_code = C; a valid key other than C grants the session to that keypad.
- Granted key appears on dc_code the next cycle.
- Next state is SESSION.
REQ-020 Simultaneous valid on both keypads in IDLE: grant goes to the keypad that is not last_owner; last_owner resets to 1, so keypad 0 wins first.
REQ-021 SESSION: busy = 1; only the owner's keys are forwarded.
- dc_code holds the last forwarded key until the next key.
- The other keypad's strobes are dropped.
REQ-022 SESSION: every forwarded key reloads the timer to KEY_TIMEOUT.
- On expiry, dc_timeout = 1 for exactly one cycle.
- The FSM stays in SESSION until dc_door or dc_alarm.
REQ-023 Owner presses C in SESSION:
- dc_code = C and dc_reset pulses for one cycle.
- Go to IDLE; fail count unchanged.
REQ-024 dc_door high in SESSION:
- Go to DOOR and clear the fail count.
- door_open = 1 for DOOR_HOLD cycles.
- Then pulse dc_reset, set dc_code = C, go to IDLE.
REQ-025 dc_alarm high in SESSION:
- Increment the fail count (saturating) and go to ALARM.
- alarm_out = 1 for ALARM_HOLD cycles.
- Then: if fail count == MAX_FAIL, go to LOCK; else pulse dc_reset and go to IDLE.
REQ-026 dc_door and dc_alarm high in the same cycle: alarm wins.
REQ-027 LOCK: locked = 1 for LOCKOUT cycles.
- All keys are ignored and dc_code = C.
- On exit: clear the fail count, pulse dc_reset, go to IDLE.
REQ-028 Keys from either keypad in DOOR, ALARM or LOCK are dropped.
REQ-029 last_owner updates on every grant.
REQ-030 Timer width = clog2 of the largest hold parameter, plus 1; the timer never wraps (loaded value counts down to 0).

Reset
REQ-031 While reset = 1, the following hold for the next cycle:
- state = IDLE, dc_code = C, dc_reset = 1, dc_timeout = 0.
- door_open = alarm_out = locked = busy = 0.
- owner = 0, last_owner = 1, fail count = 0, timer = 0.
REQ-032 Reset mid-session, mid-door or mid-lockout aborts immediately and follows REQ-031.

Structure
REQ-033 Shared package digicode_pkg holds the key encodings (ZERO..NINE, A, B, C, P) and the FSM state enum.
REQ-034 A single down-counter submodule dc_timer (load, value, expire) is shared across SESSION, DOOR, ALARM and LOCK, since these states are mutually exclusive.

Verification
REQ-035 Keypad 0 sends 2,8,B,0,4; the model raises dc_door -> door_open = 1 for 32 cycles, then dc_reset pulse, back to IDLE, fail count = 0.
REQ-036 key0_valid and key1_valid strobe together in IDLE after reset -> owner = 0; during that session keypad 1 keys never reach dc_code; the next simultaneous grant goes to owner = 1.
REQ-037 Keypad 1 sends 2 then nothing -> dc_timeout pulses once, 64 cycles after the key.
REQ-038 Three sessions each ending in dc_alarm -> alarm_out pulses of 32 cycles each; after the third, locked = 1 for 256 cycles with keys ignored.
REQ-039 Owner sends 2 then C -> one-cycle dc_reset, IDLE, fail count unchanged; then dc_door and dc_alarm high together -> ALARM.
REQ-040 Reset asserted in LOCK at cycle 100 -> next cycle locked = 0, dc_code = C, state IDLE.
